// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative RV32M multiply/divide unit. One shift-add (multiply) or restoring
//   shift-subtract (divide) step per cycle on operand magnitudes for 32 cycles.
//   A final fix-up cycle applies the sign and selects the output word.
//   Divide-by-zero and signed-overflow divides finish in one cycle.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : request an operation (sampled only when idle)
//   funct3     : 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                100 DIV, 101 DIVU, 110 REM,    111 REMU
//   operand_A  : rs1 (multiplicand / dividend)
//   operand_B  : rs2 (multiplier / divisor)
//   flush      : abort, return to idle without a done pulse
//   busy       : high whenever not idle
//   done       : one-cycle pulse, result valid in that cycle
//   result     : operation result, held until overwritten by a new result
//   stall      : combinational pipeline stall request
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] operand_A,
  input  logic [31:0] operand_B,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        stall
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Two's-complement negate when neg is set.
  function automatic logic [31:0] cond_neg32(input logic [31:0] x, input logic neg);
    cond_neg32 = neg ? (~x + 32'd1) : x;
  endfunction

  function automatic logic [63:0] cond_neg64(input logic [63:0] x, input logic neg);
    cond_neg64 = neg ? (~x + 64'd1) : x;
  endfunction

  logic [1:0]  state_q,   state_d;
  logic [5:0]  cnt_q,     cnt_d;
  logic [2:0]  op_q,      op_d;
  logic [31:0] acc_q,     acc_d;     // product high half / partial remainder
  logic [31:0] lo_q,      lo_d;      // multiplier shifting out, product low half / quotient
  logic [31:0] opnd_q,    opnd_d;    // multiplicand or divisor magnitude
  logic        neg_res_q, neg_res_d; // product/quotient must be negated
  logic        neg_rem_q, neg_rem_d; // remainder must be negated (dividend negative)
  logic [31:0] result_q,  result_d;

  logic        a_signed_s, b_signed_s, a_neg_s, b_neg_s;
  logic [31:0] mag_a_s, mag_b_s;
  logic        div_zero_s, div_ovf_s;
  logic [32:0] mul_sum_s;
  logic [32:0] div_sh_s;
  logic [33:0] div_diff_s;
  logic [63:0] prod_fix_s;
  logic [31:0] fix_result_s;
  logic [1:0]  fsm_next_s;
  logic [31:0] res_next_s;

  // Operand signedness decode: MULH/DIV/REM both signed, MULHSU only rs1 signed.
  assign a_signed_s = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b110);
  assign b_signed_s = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign a_neg_s    = a_signed_s & operand_A[31];
  assign b_neg_s    = b_signed_s & operand_B[31];
  assign mag_a_s    = cond_neg32(operand_A, a_neg_s);
  assign mag_b_s    = cond_neg32(operand_B, b_neg_s);

  assign div_zero_s = funct3[2] && (operand_B == 32'd0);
  // Only the signed forms (DIV/REM) can overflow.
  assign div_ovf_s  = funct3[2] && !funct3[0] &&
                      (operand_A == 32'h8000_0000) && (operand_B == 32'hFFFF_FFFF);

  // Multiply step: conditionally add multiplicand to the high half, then shift
  // the 65-bit {carry, acc, lo} right by one.
  assign mul_sum_s  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : 33'd0);

  // Divide step: shift the next dividend bit into the remainder and trial-subtract.
  // The partial remainder stays below the divisor, so the shifted value fits 33 bits.
  assign div_sh_s   = {acc_q, lo_q[31]};
  assign div_diff_s = {1'b0, div_sh_s} - {2'b00, opnd_q};

  assign prod_fix_s = cond_neg64({acc_q, lo_q}, neg_res_q);

  // Final sign correction and output word selection.
  always_comb begin
    fix_result_s = 32'd0;
    case (op_q)
      3'b000:                 fix_result_s = prod_fix_s[31:0];
      3'b001, 3'b010, 3'b011: fix_result_s = prod_fix_s[63:32];
      3'b100, 3'b101:         fix_result_s = cond_neg32(lo_q, neg_res_q);
      3'b110, 3'b111:         fix_result_s = cond_neg32(acc_q, neg_rem_q);
      default:                fix_result_s = 32'd0;
    endcase
  end

  // Next-state, datapath and result computation.
  always_comb begin
    fsm_next_s = state_q;
    res_next_s = result_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    acc_d      = acc_q;
    lo_d       = lo_q;
    opnd_d     = opnd_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d      = funct3;
          neg_res_d = a_neg_s ^ b_neg_s;
          neg_rem_d = a_neg_s;
          cnt_d     = 6'd0;
          acc_d     = 32'd0;
          if (div_zero_s) begin
            res_next_s = funct3[1] ? operand_A : 32'hFFFF_FFFF;
            fsm_next_s = S_DONE;
          end else if (div_ovf_s) begin
            res_next_s = funct3[1] ? 32'd0 : 32'h8000_0000;
            fsm_next_s = S_DONE;
          end else if (funct3[2]) begin
            lo_d       = mag_a_s;
            opnd_d     = mag_b_s;
            fsm_next_s = S_CALC;
          end else begin
            lo_d       = mag_b_s;
            opnd_d     = mag_a_s;
            fsm_next_s = S_CALC;
          end
        end else begin
          fsm_next_s = S_IDLE;
        end
      end
      S_CALC: begin
        if (op_q[2]) begin
          acc_d = div_diff_s[33] ? div_sh_s[31:0] : div_diff_s[31:0];
          lo_d  = {lo_q[30:0], ~div_diff_s[33]};
        end else begin
          acc_d = mul_sum_s[32:1];
          lo_d  = {mul_sum_s[0], lo_q[31:1]};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          fsm_next_s = S_FIX;
        end else begin
          fsm_next_s = S_CALC;
        end
      end
      S_FIX: begin
        res_next_s = fix_result_s;
        fsm_next_s = S_DONE;
      end
      S_DONE: begin
        fsm_next_s = S_IDLE;
      end
      default: begin
        fsm_next_s = S_IDLE;
      end
    endcase

    // Flush wins over everything, including a start in the same cycle, and
    // leaves the previous result untouched.
    if (flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end else begin
      state_d  = fsm_next_s;
      result_d = res_next_s;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 6'd0;
      op_q      <= 3'd0;
      acc_q     <= 32'd0;
      lo_q      <= 32'd0;
      opnd_q    <= 32'd0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      lo_q      <= lo_d;
      opnd_q    <= opnd_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign stall  = (start && (state_q == S_IDLE)) ||
                  ((state_q != S_IDLE) && (state_q != S_DONE));

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
//   Directed and randomized checks of muldiv_unit against an arithmetic
//   reference model (64-bit integer multiply/divide).
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] operand_A;
  logic [31:0] operand_B;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        stall;

  int tests;
  int fails;
  logic [31:0] last_result;

  muldiv_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .funct3    (funct3),
    .operand_A (operand_A),
    .operand_B (operand_B),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .stall     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit integer arithmetic following RV32M rules.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub, p, q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      3'b000: begin p = ua * ub; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin
        logic [63:0] pu;
        pu = {32'd0, a} * {32'd0, b};
        return pu[63:32];
      end
      3'b100: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = sa / sb; return q[31:0];
      end
      3'b101: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        q = ua / ub; return q[31:0];
      end
      3'b110: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        q = sa % sb; return q[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        q = ua % ub; return q[31:0];
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f[2] && b == 32'd0) return 1;
    if ((f == 3'b100 || f == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // One operation: start, scramble inputs after acceptance, watch busy/stall
  // each cycle, check latency and result, then check return to idle.
  // poke     : cycle number at which to pulse a spurious start (0 = none)
  // poke_done: raise start during the done cycle only
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int poke, input bit poke_done);
    logic [31:0] exp;
    int exp_lat;
    int lat;
    exp     = ref_result(f, a, b);
    exp_lat = ref_latency(f, a, b);
    @(negedge clk);
    start = 1'b1; funct3 = f; operand_A = a; operand_B = b;
    #1 check("stall_on_start", 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    funct3 = 3'($urandom); operand_A = $urandom; operand_B = $urandom;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == poke) begin
        start = 1'b1; funct3 = 3'($urandom); operand_A = $urandom; operand_B = $urandom;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        lat = k;
        break;
      end
      check("busy_calc", 32'(busy), 32'd1);
      check("stall_calc", 32'(stall), 32'd1);
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("result", result, exp);
    check("busy_in_done", 32'(busy), 32'd1);
    if (poke_done) begin
      start = 1'b1; funct3 = 3'b000; operand_A = 32'd9; operand_B = 32'd9;
    end else begin
      start = 1'b0;
    end
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("idle_after_done", 32'(busy), 32'd0);
    check("done_one_cycle", 32'(done), 32'd0);
    check("result_hold", result, exp);
    last_result = exp;
  endtask

  initial begin
    bit seen_done;
    logic [2:0] f;
    tests = 0; fails = 0;
    rst_n = 1'b1; start = 1'b0; flush = 1'b0;
    funct3 = 3'd0; operand_A = 32'd0; operand_B = 32'd0;
    #2 rst_n = 1'b0;
    #10;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 0, 1'b0);
    check("mul_7_m3", last_result, 32'hFFFF_FFEB);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(3'b010, 32'hFFFF_FFFF, 32'd2, 0, 1'b0);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    run_op(3'b101, 32'd100, 32'd7, 0, 1'b0);
    run_op(3'b111, 32'd100, 32'd7, 0, 1'b0);
    run_op(3'b101, 32'd5, 32'd0, 0, 1'b0);
    run_op(3'b111, 32'd5, 32'd0, 0, 1'b0);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);

    // Start while busy, and start only during the done cycle, are both ignored
    run_op(3'b001, 32'h1234_5678, 32'h9ABC_DEF0, 12, 1'b0);
    run_op(3'b000, 32'd3, 32'd5, 0, 1'b1);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom);
      run_op(f, pick_val(), pick_val(), 0, 1'b0);
    end

    // Flush has priority over start in idle
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = 3'b000; operand_A = 32'd2; operand_B = 32'd2;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    check("flush_over_start", 32'(busy), 32'd0);

    // Flush at CALC cycle 10
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; operand_A = 32'd11; operand_B = 32'd13;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_idle", 32'(busy), 32'd0);
    check("flush_no_done", 32'(done), 32'd0);
    check("flush_result_kept", result, last_result);
    seen_done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("flush_never_done", 32'(seen_done), 32'd0);

    // Asynchronous reset at CALC cycle 20
    @(negedge clk);
    start = 1'b1; funct3 = 3'b100; operand_A = 32'd1000; operand_B = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 20; k++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_stall", 32'(stall), 32'd0);
    #2 rst_n = 1'b1;
    run_op(3'b101, 32'd100, 32'd7, 0, 1'b0);
    check("after_reset_divu", last_result, 32'd14);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, request a new M-extension operation; sampled only in IDLE.
REQ-004 SHALL have port funct3, input, 3, operation select:
- 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
- 100 DIV, 101 DIVU, 110 REM, 111 REMU
REQ-005 SHALL have port operand_A, input, 32, rs1 value (multiplicand/dividend).
REQ-006 SHALL have port operand_B, input, 32, rs2 value (multiplier/divisor).
REQ-007 SHALL have port flush, input, 1, abort the current operation.
REQ-008 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-009 SHALL have port done, output, 1, one-cycle pulse; result is valid in that cycle.
REQ-010 SHALL have port result, output, 32, operation result; holds its value until the next accepted start.
REQ-011 SHALL have port stall, output, 1, combinational: (start and state==IDLE) or (state not IDLE and not DONE).

Function
REQ-012 SHALL implement states IDLE, CALC, FIX, DONE.
REQ-013 In IDLE with start=1 at edge T, SHALL latch funct3 and both operands, then enter CALC.
- Exception: special cases per REQ-018/019 enter DONE directly.
REQ-014 CALC SHALL iterate exactly 32 cycles using a 6-bit counter cleared on entry.
- Multiply: one shift-add step per cycle on operand magnitudes.
- Divide: one restoring shift-subtract step per cycle on operand magnitudes.
REQ-015 Operand signedness SHALL be:
- Both operands signed: MULH, DIV, REM.
- operand_A signed, operand_B unsigned: MULHSU.
- Both unsigned: MULHU, DIVU, REMU.
- MUL: signedness irrelevant (low 32 bits identical).
REQ-016 FIX (one cycle) SHALL apply sign correction and select the output:
- Product: negate the 64-bit product if the operand signs differ; MUL returns bits [31:0], MULH/MULHSU/MULHU return bits [63:32].
- Quotient: negate if the signed operand signs differ.
- Remainder: takes the sign of the dividend.
REQ-017 DONE SHALL last one cycle with done=1, then return to IDLE.
- Normal latency: done asserted in the cycle after edge T+33, i.e. 34 cycles after start.
REQ-018 Divide by zero (operand_B==0, funct3[2]=1) SHALL go IDLE->DONE, with done one cycle after start:
- DIV/DIVU result = 0xFFFFFFFF.
- REM/REMU result = operand_A.
REQ-019 Signed overflow (DIV/REM, operand_A=0x80000000, operand_B=0xFFFFFFFF) SHALL go IDLE->DONE:
- DIV result = 0x80000000.
- REM result = 0.
REQ-020 start while busy SHALL be ignored; no queuing.
REQ-021 flush in any state SHALL force IDLE on the next edge, with no done pulse and result unchanged.
- flush takes priority over start in the same cycle.
REQ-022 start asserted in the DONE cycle SHALL be ignored; it must be held into IDLE to be accepted.
REQ-023 Operand inputs changing after acceptance SHALL NOT affect the result.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, result=0, and counter=0, including mid-operation.
REQ-025 After rst_n deasserts, the first start SHALL be accepted on the first rising edge.

Verification
REQ-026 MUL, A=7, B=0xFFFFFFFD -> result 0xFFFFFFEB, done exactly 34 cycles after start, busy high for cycles 1-34.
REQ-027 MULHU, A=B=0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU A=0xFFFFFFFF, B=2 -> 0xFFFFFFFF.
REQ-028 DIV, A=0xFFFFFFF9 (-7), B=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-029 DIVU, A=5, B=0 -> 0xFFFFFFFF with done 1 cycle after start; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 in 1 cycle.
REQ-030 Flush and reset aborts: flush at CALC cycle 10 -> IDLE next cycle, no done, prior result retained; rst_n low at CALC cycle 20 -> all outputs 0 asynchronously; new start then completes correctly.
